// File: rtl/param_selector_pkg.sv
// Shared constants, button indices and debouncer state encoding for the
// parameter selector.
package param_selector_pkg;

    // Frequency index limits and reset value
    localparam logic [3:0] BF_MIN     = 4'd1;
    localparam logic [3:0] BF_MAX     = 4'd8;
    localparam logic [3:0] BF_RST     = 4'd1;

    // Duty-cycle count limits (tens of percent) and reset value
    localparam logic [3:0] BC_MIN     = 4'd0;
    localparam logic [3:0] BC_MAX     = 4'd10;
    localparam logic [3:0] BC_RST     = 4'd5;

    // 1 = frequency index selected, 0 = duty-cycle count selected
    localparam logic       OPCION_RST = 1'b1;

    // Positions of the buttons in the internal button vectors
    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_MODE = 2;
    localparam int BTN_NUM  = 3;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    // One saturating step: +1 on inc, -1 on dec, never leaving [lo, hi].
    // Callers guarantee inc and dec are never both set.
    function automatic logic [3:0] step_sat(
        input logic [3:0] val,
        input logic       inc,
        input logic       dec,
        input logic [3:0] lo,
        input logic [3:0] hi
    );
        logic [3:0] res;
        res = val;
        if (inc && (val < hi)) begin
            res = val + 4'd1;
        end else if (dec && (val > lo)) begin
            res = val - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/param_selector_debounce.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM and an
// optional auto-repeat that re-fires the press pulse while the button is held.
module btn_debounce
    import param_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_state;
    db_state_t     w_state_next;
    logic [DW-1:0] r_db_cnt;
    logic [DW-1:0] w_db_cnt_next;
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_cnt_next;
    logic          w_press;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state and its stability / repeat counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= DB_RELEASED;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_db_cnt  <= w_db_cnt_next;
            r_rep_cnt <= w_rep_cnt_next;
        end
    end

    // Next-state, counter and press-pulse decode. Counters idle at zero in
    // any state that does not use them, so every entry starts a fresh count.
    // The repeat pulse depends only on time spent in PRESSED, so a step that
    // falls due on the same cycle the release is first seen still fires.
    always_comb begin
        w_state_next   = r_state;
        w_db_cnt_next  = '0;
        w_rep_cnt_next = '0;
        w_press        = 1'b0;
        case (r_state)
            DB_RELEASED: begin
                if (r_sync2) begin
                    w_state_next = DB_PRESS_WAIT;
                end
            end
            DB_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_next = DB_RELEASED;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_next = DB_PRESSED;
                    w_press      = 1'b1;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end
            DB_PRESSED: begin
                if (!r_sync2) begin
                    w_state_next = DB_RELEASE_WAIT;
                end
                if (r_rep_cnt == REP_LAST) begin
                    w_press = REPEAT_EN;
                end else begin
                    w_rep_cnt_next = r_rep_cnt + RW'(1);
                end
            end
            DB_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_next = DB_PRESSED;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_next = DB_RELEASED;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end
            default: begin
                w_state_next = DB_RELEASED;
            end
        endcase
    end

    assign o_press = w_press;

endmodule

// File: rtl/param_selector.sv
// Three-button parameter selector: up/down step the selected parameter with
// saturation, mode swaps which parameter is selected, and changed flags any
// value update one cycle after it lands in the output registers.
module param_selector
    import param_selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic       opcion,
    output logic [3:0] bf,
    output logic [3:0] bc,
    output logic       changed
);

    logic [BTN_NUM-1:0] w_btn_raw;
    logic [BTN_NUM-1:0] w_press;

    logic       r_opcion;
    logic [3:0] r_bf;
    logic [3:0] r_bc;
    logic       r_alter;
    logic       r_changed;

    logic       w_inc;
    logic       w_dec;
    logic       w_opcion_next;
    logic [3:0] w_bf_next;
    logic [3:0] w_bc_next;
    logic       w_alter;

    assign w_btn_raw[BTN_UP]   = btn_up;
    assign w_btn_raw[BTN_DOWN] = btn_down;
    assign w_btn_raw[BTN_MODE] = btn_mode;

    // One conditioner per button; mode toggles must never auto-repeat
    for (genvar gi = 0; gi < BTN_NUM; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (gi != BTN_MODE)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (w_btn_raw[gi]),
            .o_press (w_press[gi])
        );
    end

    // Value update rules: up and down together cancel, the step acts on the
    // parameter selected before any same-cycle mode toggle
    always_comb begin
        w_inc         = w_press[BTN_UP] & ~w_press[BTN_DOWN];
        w_dec         = w_press[BTN_DOWN] & ~w_press[BTN_UP];
        w_opcion_next = r_opcion ^ w_press[BTN_MODE];
        w_bf_next     = r_bf;
        w_bc_next     = r_bc;
        if (r_opcion) begin
            w_bf_next = step_sat(r_bf, w_inc, w_dec, BF_MIN, BF_MAX);
        end else begin
            w_bc_next = step_sat(r_bc, w_inc, w_dec, BC_MIN, BC_MAX);
        end
        w_alter = (w_opcion_next != r_opcion) || (w_bf_next != r_bf)
               || (w_bc_next != r_bc);
    end

    // Output registers; changed trails the altering update by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opcion  <= OPCION_RST;
            r_bf      <= BF_RST;
            r_bc      <= BC_RST;
            r_alter   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_opcion  <= w_opcion_next;
            r_bf      <= w_bf_next;
            r_bc      <= w_bc_next;
            r_alter   <= w_alter;
            r_changed <= r_alter;
        end
    end

    assign opcion  = r_opcion;
    assign bf      = r_bf;
    assign bc      = r_bc;
    assign changed = r_changed;

endmodule

// File: tb/tb_param_selector.sv
// Bench for param_selector with short debounce/repeat times: directed latency
// and reset sequences, a table of press scenarios, and randomized button
// traffic compared every cycle against a behavioural model.
module tb_param_selector;

    localparam int D = 4;
    localparam int R = 16;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic       opcion;
    logic [3:0] bf;
    logic [3:0] bc;
    logic       changed;

    int n_checks;
    int n_fail;
    int chg_count;

    param_selector #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_mode (btn_mode),
        .opcion   (opcion),
        .bf       (bf),
        .bc       (bc),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. Each button is described by its accepted level and
    // the length of the current run of synchronized samples that disagree
    // with it; a level change is accepted on the (D+1)th disagreeing sample
    // (one to notice, D to confirm). While held and not bouncing, a repeat
    // step falls due every R cycles. Values follow the saturation rules
    // directly with integer arithmetic.
    // ------------------------------------------------------------------
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_acc [3];
    int m_run [3];
    int m_hold [3];
    int m_opc, m_bf, m_bc;
    bit m_alt, m_chg;

    task automatic model_step();
        bit raw [3];
        bit p [3];
        bit samp;
        int nbf, nbc, nopc;
        raw[0] = btn_up;
        raw[1] = btn_down;
        raw[2] = btn_mode;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_acc[i] = 0; m_run[i] = 0; m_hold[i] = 0;
            end
            m_opc = 1; m_bf = 1; m_bc = 5; m_alt = 0; m_chg = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            p[i] = 0;
            samp = m_s2[i];
            if (!m_acc[i]) begin
                if (samp) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i] = 1; m_run[i] = 0; m_hold[i] = 0; p[i] = 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                bit held_steady;
                held_steady = (m_run[i] == 0);
                if (held_steady && i != 2 && m_hold[i] == R - 1) p[i] = 1;
                m_hold[i] = held_steady ? ((m_hold[i] + 1) % R) : 0;
                if (!samp) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i] = 0; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        nbf = m_bf; nbc = m_bc; nopc = m_opc;
        if (p[0] != p[1]) begin
            if (m_opc == 1) nbf = p[0] ? ((m_bf < 8) ? m_bf + 1 : m_bf) : ((m_bf > 1) ? m_bf - 1 : m_bf);
            else            nbc = p[0] ? ((m_bc < 10) ? m_bc + 1 : m_bc) : ((m_bc > 0) ? m_bc - 1 : m_bc);
        end
        if (p[2]) nopc = 1 - m_opc;
        m_chg = m_alt;
        m_alt = (nbf != m_bf) || (nbc != m_bc) || (nopc != m_opc);
        m_bf = nbf; m_bc = nbc; m_opc = nopc;
    endtask

    // One clock: the model consumes the inputs present at the edge, outputs
    // are sampled 1 time unit later, and changed pulses are tallied.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (changed === 1'b1) chg_count++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit up;
        bit down;
        bit mode;
        int e_opc;
        int e_bf;
        int e_bc;
        int e_chg;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int dur [3];
        logic [31:0] exp_v;
        n_checks = 0;
        n_fail = 0;
        chg_count = 0;
        rst_n = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;

        // Starting state opcion=1 bf=3 bc=5 (after the up-hold sequence)
        vecs[0]  = '{0,0,1, 0,3,5, 1};
        vecs[1]  = '{0,1,0, 0,3,4, 1};
        vecs[2]  = '{0,1,0, 0,3,3, 1};
        vecs[3]  = '{0,1,0, 0,3,2, 1};
        vecs[4]  = '{0,1,0, 0,3,1, 1};
        vecs[5]  = '{0,1,0, 0,3,0, 1};
        vecs[6]  = '{0,1,0, 0,3,0, 0};
        vecs[7]  = '{0,0,1, 1,3,0, 1};
        vecs[8]  = '{1,0,0, 1,4,0, 1};
        vecs[9]  = '{1,0,0, 1,5,0, 1};
        vecs[10] = '{1,0,0, 1,6,0, 1};
        vecs[11] = '{1,0,0, 1,7,0, 1};
        vecs[12] = '{1,0,0, 1,8,0, 1};
        vecs[13] = '{1,0,0, 1,8,0, 0};
        vecs[14] = '{1,1,0, 1,8,0, 0};
        vecs[15] = '{0,1,0, 1,7,0, 1};
        vecs[16] = '{1,0,1, 0,8,0, 1};
        vecs[17] = '{0,1,0, 0,8,0, 0};
        vecs[18] = '{1,0,0, 0,8,1, 1};

        // Reset with idle buttons
        ticks(3);
        rst_n = 1'b1;
        tick();
        check("reset_opcion", {31'd0, opcion}, 32'd1);
        check("reset_bf", {28'd0, bf}, 32'd1);
        check("reset_bc", {28'd0, bc}, 32'd5);
        check("reset_changed", {31'd0, changed}, 32'd0);
        ticks(2);

        // Up held 20 cycles: first step D+3 edges after the raw edge, one
        // repeat step R cycles after that, changed one cycle after each step
        chg_count = 0;
        btn_up = 1'b1;
        ticks(D + 2);
        check("up_latency_before", {28'd0, bf}, 32'd1);
        tick();
        check("up_latency_at", {28'd0, bf}, 32'd2);
        check("up_changed_not_yet", {31'd0, changed}, 32'd0);
        tick();
        check("up_changed_pulse", {31'd0, changed}, 32'd1);
        tick();
        check("up_changed_single", {31'd0, changed}, 32'd0);
        ticks(11);
        btn_up = 1'b0;
        ticks(2);
        check("up_repeat_before", {28'd0, bf}, 32'd2);
        tick();
        check("up_repeat_at", {28'd0, bf}, 32'd3);
        ticks(15);
        check("up_hold_changed_count", chg_count, 32'd2);
        check("up_hold_bc", {28'd0, bc}, 32'd5);

        // Table of single clean presses
        for (int v = 0; v < 19; v++) begin
            chg_count = 0;
            btn_up = vecs[v].up;
            btn_down = vecs[v].down;
            btn_mode = vecs[v].mode;
            ticks(D + 5);
            btn_up = 1'b0;
            btn_down = 1'b0;
            btn_mode = 1'b0;
            ticks(12);
            check($sformatf("vec%0d_opcion", v), {31'd0, opcion}, vecs[v].e_opc);
            check($sformatf("vec%0d_bf", v), {28'd0, bf}, vecs[v].e_bf);
            check($sformatf("vec%0d_bc", v), {28'd0, bc}, vecs[v].e_bc);
            check($sformatf("vec%0d_changed", v), chg_count, vecs[v].e_chg);
        end

        // Short glitches on up never qualify (state: opcion=0 bf=8 bc=1)
        chg_count = 0;
        for (int g = 0; g < 4; g++) begin
            btn_up = 1'b1;
            ticks(3);
            btn_up = 1'b0;
            ticks(3);
        end
        ticks(10);
        check("glitch_bc", {28'd0, bc}, 32'd1);
        check("glitch_bf", {28'd0, bf}, 32'd8);
        check("glitch_changed", chg_count, 32'd0);

        // Reset while up sits in PRESS_WAIT; still held afterwards
        btn_up = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        ticks(2);
        check("midreset_opcion", {31'd0, opcion}, 32'd1);
        check("midreset_bf", {28'd0, bf}, 32'd1);
        check("midreset_bc", {28'd0, bc}, 32'd5);
        rst_n = 1'b1;
        ticks(D + 2);
        check("postreset_before", {28'd0, bf}, 32'd1);
        tick();
        check("postreset_at", {28'd0, bf}, 32'd2);
        btn_up = 1'b0;
        ticks(15);

        // Randomized traffic against the model
        for (int i = 0; i < 3; i++) dur[i] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    if (i == 0) btn_up = ~btn_up;
                    else if (i == 1) btn_down = ~btn_down;
                    else btn_mode = ~btn_mode;
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 60);
                end
            end
            rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            tick();
            exp_v = {21'd0, m_opc[0], m_bf[3:0], m_bc[3:0], 1'b0, m_chg, 1'b0};
            check("rand_cycle", {21'd0, opcion, bf, bc, 1'b0, changed, 1'b0}, exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_selector.md
PARAM_SELECTOR -- requirements
Module: param_selector

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, meaning hold time per auto-repeat step.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-005 SHALL have port btn_up  input  1  raw asynchronous push-button, active-high, increments the selected parameter.
REQ-006 SHALL have port btn_down  input  1  raw asynchronous push-button, active-high, decrements the selected parameter.
REQ-007 SHALL have port btn_mode  input  1  raw asynchronous push-button, active-high, toggles the selected parameter.
REQ-008 SHALL have port opcion  output  1  registered mode: 1 = frequency index selected, 0 = duty-cycle count selected.
REQ-009 SHALL have port bf  output  4  registered frequency index, range 1..8.
REQ-010 SHALL have port bc  output  4  registered duty-cycle count, range 0..10 (tens of percent).
REQ-011 SHALL have port changed  output  1  registered one-cycle pulse when opcion, bf or bc changes value.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each debouncer SHALL be a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED->PRESS_WAIT on synced level 1; PRESS_WAIT->PRESSED after DEBOUNCE_CYCLES consecutive 1s; any 0 in PRESS_WAIT returns to RELEASED and clears the count.
REQ-015 PRESSED->RELEASE_WAIT on synced 0; RELEASE_WAIT->RELEASED after DEBOUNCE_CYCLES consecutive 0s; any 1 in RELEASE_WAIT returns to PRESSED.
REQ-016 Each debouncer SHALL emit a one-cycle press pulse on the PRESS_WAIT->PRESSED transition.
REQ-017 Up/down debouncers SHALL emit a further press pulse every REPEAT_CYCLES while in PRESSED; the mode debouncer SHALL NOT auto-repeat.
REQ-018 Latency from a raw edge held stable to the output register update SHALL be exactly DEBOUNCE_CYCLES+3 clocks.
REQ-019 An up pulse with opcion=1 SHALL set bf to bf+1, saturating at 8; with opcion=0 it SHALL set bc to bc+1, saturating at 10.
REQ-020 A down pulse with opcion=1 SHALL set bf to bf-1, saturating at 1; with opcion=0 it SHALL set bc to bc-1, saturating at 0.
REQ-021 No wrap-around SHALL occur; saturated presses SHALL leave values unchanged and SHALL NOT assert changed.
REQ-022 Simultaneous up and down pulses in the same cycle SHALL be ignored.
REQ-023 A mode pulse SHALL invert opcion; an up/down pulse in the same cycle SHALL act on the pre-toggle opcion value.
REQ-024 The non-selected parameter SHALL hold its value.
REQ-025 changed SHALL assert one cycle after any register update that alters a value, for exactly one cycle.

Reset
REQ-026 While rst_n=0 at a clk edge: opcion=1, bf=1, bc=5, changed=0, all debouncers RELEASED with counters cleared, synchronizers 0.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard the pending press; a button still held after reset SHALL require a full DEBOUNCE_CYCLES before its press pulse.

Structure
REQ-028 Package param_selector_pkg SHALL hold BF_MIN=1, BF_MAX=8, BC_MIN=0, BC_MAX=10, BF_RST=1, BC_RST=5, OPCION_RST=1, and the debouncer state encoding.
REQ-029 Sub-module btn_debounce (synchronizer, FSM, counters, press pulse, repeat enable) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-030 Reset release, no buttons -> opcion=1, bf=1, bc=5, changed=0.
REQ-031 btn_up held 20 cycles with opcion=1 -> bf=2 exactly 7 cycles after the edge, changed pulses once, then bf=3 16 cycles later.
REQ-032 btn_up 3-cycle glitches repeated -> bf unchanged, no changed pulse.
REQ-033 Mode press, then 6 clean down presses -> opcion=0, bc 5->0, final press leaves bc=0 with no changed pulse.
REQ-034 Up and down pressed identically from bf=8 -> no change; then up alone -> bf stays 8, no changed pulse.
REQ-035 rst_n pulsed low while btn_up in PRESS_WAIT -> no increment; button held -> bf increments DEBOUNCE_CYCLES+3 cycles after rst_n rises.
